// File: rtl/mac_dot_accumulator_pkg.sv
// Shared types and default sizes for the dot-product accumulator.
// MAC_ACC_SATURATE_EN: when defined, the accumulator clamps on overflow
// instead of wrapping. The macro is consumed by the adder.
package mac_pkg;

    localparam int unsigned PROD_W_DEF = 16;
    localparam int unsigned ACC_W_DEF  = 24;
    localparam int unsigned LEN_W_DEF  = 8;

    // All-ones value the accumulator clamps to when saturation is enabled
    localparam logic [ACC_W_DEF-1:0] ACC_SAT_MAX = {ACC_W_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/mac_dot_accumulator_if.sv
// Product input and result output handshakes of the dot-product accumulator.
// The master drives products and accepts results; the slave is the accumulator.
interface mac_dot_accumulator_if
    import mac_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_ovf;

    modport master (
        output in_valid,
        output in_prod,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_ovf
    );

    modport slave (
        input  in_valid,
        input  in_prod,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_ovf
    );

endinterface

// File: rtl/mac_dot_accumulator_adder.sv
// Combinational accumulate step: acc + zero-extended product, with carry out.
// MAC_ACC_SATURATE_EN: when defined, a carry clamps the sum to all-ones;
// otherwise the sum wraps modulo 2^ACC_W. The carry is reported either way.
module mac_acc_adder
    import mac_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  i_acc,
    input  logic [PROD_W-1:0] i_prod,
    output logic [ACC_W-1:0]  o_sum_c,
    output logic              o_carry_c
);

    logic [ACC_W:0] w_sum_ext;

    // One extra bit captures the carry out of the accumulator MSB
    always_comb begin
        w_sum_ext = {1'b0, i_acc} + (ACC_W+1)'(i_prod);
    end

    assign o_carry_c = w_sum_ext[ACC_W];

`ifdef MAC_ACC_SATURATE_EN
    assign o_sum_c = o_carry_c ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
    assign o_sum_c = w_sum_ext[ACC_W-1:0];
`endif

endmodule

// File: rtl/mac_dot_accumulator.sv
// Sequential dot-product accumulator: sums a programmed number of unsigned
// products received over a valid/ready stream and presents the sum plus a
// sticky overflow flag on a result handshake.
// MAC_ACC_SATURATE_EN: when defined, the accumulator saturates on overflow.
module mac_dot_accumulator
    import mac_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    mac_dot_accumulator_if.slave   bus,
    output logic                   busy
);

    state_e             r_state;
    state_e             w_state_nxt;

    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic [LEN_W-1:0]   r_count;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_sum;
    logic               r_out_ovf;
    logic               r_busy;

    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic               w_busy_nxt;

    logic [ACC_W-1:0]   w_acc_add;
    logic               w_carry;
    logic               w_start_job;
    logic               w_len_zero;
    logic               w_in_hs;
    logic               w_last;
    logic               w_out_hs;

    assign w_start_job = (r_state == IDLE) && start;
    assign w_len_zero  = (len == '0);
    assign w_in_hs     = bus.in_valid && r_in_ready;
    assign w_last      = w_in_hs && (r_count == LEN_W'(1));
    assign w_out_hs    = r_out_valid && bus.out_ready;

    mac_acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .i_acc     (r_acc),
        .i_prod    (bus.in_prod),
        .o_sum_c   (w_acc_add),
        .o_carry_c (w_carry)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = w_len_zero ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_out_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the flags register in step with it
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b1;
        case (w_state_nxt)
            IDLE:    w_busy_nxt      = 1'b0;
            ACCUM:   w_in_ready_nxt  = 1'b1;
            DONE:    w_out_valid_nxt = 1'b1;
            default: w_busy_nxt      = 1'b0;
        endcase
    end

    // Registered handshake and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Accumulator, remaining-product counter and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_count   <= '0;
            r_out_sum <= '0;
            r_out_ovf <= 1'b0;
        end else if (w_start_job) begin
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= len;
            if (w_len_zero) begin
                r_out_sum <= '0;
                r_out_ovf <= 1'b0;
            end
        end else if (w_in_hs) begin
            r_acc   <= w_acc_add;
            r_ovf   <= r_ovf | w_carry;
            r_count <= r_count - LEN_W'(1);
            if (w_last) begin
                r_out_sum <= w_acc_add;
                r_out_ovf <= r_ovf | w_carry;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_ovf   = r_out_ovf;
    assign busy          = r_busy;

endmodule

// File: tb/tb_mac_dot_accumulator.sv
// Directed bench for the dot-product accumulator with an expected-result queue.
module tb_mac_dot_accumulator;
    import mac_pkg::*;

    localparam int unsigned PROD_W  = 16;
    localparam int unsigned ACC_W   = 24;
    localparam int unsigned ACC_W16 = 16;
    localparam int unsigned LEN_W   = 8;

    typedef struct {
        longint unsigned sum;
        bit              ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             start16;
    logic [LEN_W-1:0] len16;
    logic             busy16;

    mac_dot_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W))   bus ();
    mac_dot_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W16)) bus16 ();

    mac_dot_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .len   (len),
        .bus   (bus.slave),
        .busy  (busy)
    );

    mac_dot_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W16), .LEN_W(LEN_W)) dut16 (
        .clk   (clk),
        .reset (reset),
        .start (start16),
        .len   (len16),
        .bus   (bus16.slave),
        .busy  (busy16)
    );

    always #5 clk = ~clk;

    int              checks = 0;
    int              errors = 0;
    exp_t            exp_q[$];
    longint unsigned prod_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference sum of the queued products at the given accumulator width
    function automatic exp_t model(input int unsigned width);
        exp_t            e;
        longint unsigned acc;
        longint unsigned s;
        longint unsigned max_v;
        max_v = (64'd1 << width) - 64'd1;
        acc   = 0;
        e.ovf = 1'b0;
        foreach (prod_q[i]) begin
            s = acc + prod_q[i];
            if (s > max_v) begin
                e.ovf = 1'b1;
`ifdef MAC_ACC_SATURATE_EN
                acc = max_v;
`else
                acc = s & max_v;
`endif
            end else begin
                acc = s;
            end
        end
        e.sum = acc;
        return e;
    endfunction

    // Runs one job on the 24-bit instance using the products in prod_q
    task automatic run_job(input int gap, input int hold, input bit poke);
        exp_t e;
        int   n;
        n = prod_q.size();
        exp_q.push_back(model(ACC_W));
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        if (n == 0) begin
            check("len0_in_ready_low", 64'(bus.in_ready), 64'(0));
        end
        foreach (prod_q[i]) begin
            bus.in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
                if (poke) begin
                    start = 1'b1;
                    len   = LEN_W'(1);
                end
                step();
                start = 1'b0;
                check("accum_hold_in_ready", 64'(bus.in_ready), 64'(1));
            end
            bus.in_valid = 1'b1;
            bus.in_prod  = PROD_W'(prod_q[i]);
            step();
        end
        bus.in_valid = 1'b0;
        check("out_valid_latency", 64'(bus.out_valid), 64'(1));
        check("done_in_ready_low", 64'(bus.in_ready), 64'(0));
        if (bus.out_valid === 1'b1 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end else begin
            e = exp_q.pop_front();
            check("result_missing", 64'(bus.out_valid), 64'(1));
        end
        check("out_sum", 64'(bus.out_sum), e.sum);
        check("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
        for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            if (poke) begin
                start = 1'b1;
                len   = LEN_W'(3);
            end
            step();
            check("hold_out_valid", 64'(bus.out_valid), 64'(1));
            check("hold_out_sum", 64'(bus.out_sum), e.sum);
            check("hold_in_ready_low", 64'(bus.in_ready), 64'(0));
        end
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("idle_out_valid", 64'(bus.out_valid), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_in_ready", 64'(bus.in_ready), 64'(0));
        check("held_sum_after_pop", 64'(bus.out_sum), e.sum);
        prod_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e16;
        reset           = 1'b1;
        start           = 1'b0;
        len             = '0;
        bus.in_valid    = 1'b0;
        bus.in_prod     = '0;
        bus.out_ready   = 1'b0;
        start16         = 1'b0;
        len16           = '0;
        bus16.in_valid  = 1'b0;
        bus16.in_prod   = '0;
        bus16.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        check("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_sum", 64'(bus.out_sum), 64'(0));
        check("rst_out_ovf", 64'(bus.out_ovf), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));

        // Products offered in IDLE are not accepted
        bus.in_valid = 1'b1;
        bus.in_prod  = PROD_W'(55);
        step();
        step();
        check("idle_in_valid_in_ready", 64'(bus.in_ready), 64'(0));
        check("idle_in_valid_busy", 64'(busy), 64'(0));
        bus.in_valid = 1'b0;

        // Back-to-back 100,200,300
        prod_q = '{100, 200, 300};
        run_job(0, 0, 1'b0);

        // Zero-length job
        run_job(0, 0, 1'b0);

        // Two-cycle gaps, result held with out_ready low for 5 cycles
        prod_q = '{1, 2, 3, 4};
        run_job(2, 5, 1'b0);

        // Start pulses during ACCUM and DONE must be ignored
        prod_q = '{5, 6};
        run_job(1, 2, 1'b1);
        step();
        check("poke_no_restart", 64'(busy), 64'(0));

        // Longest job of maximum products: fits in 24 bits
        for (int i = 0; i < 255; i++) prod_q.push_back(65025);
        run_job(0, 0, 1'b0);

        // 16-bit accumulator overflows on two maximum products
        prod_q = '{65025, 65025};
        e16 = model(ACC_W16);
        prod_q.delete();
        start16 = 1'b1;
        len16   = LEN_W'(2);
        step();
        start16 = 1'b0;
        bus16.in_valid = 1'b1;
        bus16.in_prod  = PROD_W'(65025);
        step();
        step();
        bus16.in_valid = 1'b0;
        check("w16_out_valid", 64'(bus16.out_valid), 64'(1));
`ifdef MAC_ACC_SATURATE_EN
        check("w16_out_sum", 64'(bus16.out_sum), 64'(65535));
`else
        check("w16_out_sum", 64'(bus16.out_sum), 64'(64514));
`endif
        check("w16_model_sum", 64'(bus16.out_sum), e16.sum);
        check("w16_out_ovf", 64'(bus16.out_ovf), 64'(1));
        bus16.out_ready = 1'b1;
        step();
        bus16.out_ready = 1'b0;
        check("w16_idle", 64'(busy16), 64'(0));

        // Reset mid-job after 2 of 5 products discards the job
        start = 1'b1;
        len   = LEN_W'(5);
        step();
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_prod  = PROD_W'(50);
        step();
        step();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_in_ready", 64'(bus.in_ready), 64'(0));
        check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
        check("midrst_out_sum", 64'(bus.out_sum), 64'(0));
        check("midrst_out_ovf", 64'(bus.out_ovf), 64'(0));
        step();
        check("midrst_no_result", 64'(bus.out_valid), 64'(0));

        prod_q = '{7};
        run_job(0, 0, 1'b0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
